// File: rtl/scan_mux.sv
// Registered N-channel valid/ready multiplexer with manual select or round-robin scan.
// Optional registered one-hot channel output when SCAN_MUX_ONEHOT_EN is defined.
module scan_mux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      sel_load,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
`ifdef SCAN_MUX_ONEHOT_EN
  output logic [CHANNELS-1:0]       out_chan_onehot,
`endif
  input  logic                      out_ready
);

  logic [SEL_W-1:0]    cur_reg;
  logic [SEL_W-1:0]    cur_next;
  logic [SEL_W-1:0]    cur_inc;
  logic [CHANNELS-1:0] cur_hot;
  logic                cur_valid;
  logic [WIDTH-1:0]    cur_data;
  logic                room;
  logic                capture;
  logic                sel_ok;
  logic                advance;

  assign room = !out_valid || out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign cur_hot[gi]  = (cur_reg == SEL_W'(gi));
      // Held low during reset even though room is already true then.
      assign in_ready[gi] = cur_hot[gi] && room && !reset;
    end
  endgenerate

  always_comb begin
    cur_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cur_hot[i]) cur_data = cur_data | in_data[i*WIDTH +: WIDTH];
    end
  end

  assign cur_valid = |(in_valid & cur_hot);
  assign capture   = |(in_valid & in_ready);

  // Out-of-range select values are ignored so cur never points past the last channel.
  assign sel_ok  = sel_load && ({1'b0, sel} < (SEL_W+1)'(CHANNELS));
  assign advance = mode && (capture || !cur_valid);
  assign cur_inc = (cur_reg == SEL_W'(CHANNELS-1)) ? '0 : cur_reg + SEL_W'(1);

  always_comb begin
    cur_next = cur_reg;
    if (sel_ok)       cur_next = sel;
    else if (advance) cur_next = cur_inc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur_reg <= '0;
    else       cur_reg <= cur_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data  <= '0;
      out_chan  <= '0;
      out_valid <= 1'b0;
    end else if (capture) begin
      out_data  <= cur_data;
      out_chan  <= cur_reg;
      out_valid <= 1'b1;
    end else if (room) begin
      out_valid <= 1'b0;
    end
  end

`ifdef SCAN_MUX_ONEHOT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        out_chan_onehot <= '0;
    else if (capture) out_chan_onehot <= cur_hot;
    else if (room)    out_chan_onehot <= '0;
  end
`endif

endmodule

// File: tb/tb_scan_mux.sv
// Scoreboard bench for scan_mux: a reference model predicts captures and queues the words.
module tb_scan_mux;
  localparam int W  = 8;
  localparam int CH = 4;
  localparam int SW = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [CH*W-1:0] in_data;
  logic [CH-1:0]   in_valid;
  logic [CH-1:0]   in_ready;
  logic            mode;
  logic [SW-1:0]   sel;
  logic            sel_load;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_chan;
  logic            out_valid;
  logic            out_ready;
`ifdef SCAN_MUX_ONEHOT_EN
  logic [CH-1:0]   out_chan_onehot;
`endif

  scan_mux #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .sel_load(sel_load),
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
`ifdef SCAN_MUX_ONEHOT_EN
    .out_chan_onehot(out_chan_onehot),
`endif
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [SW-1:0] chan; logic [W-1:0] data; } word_t;
  word_t exp_q[$];

  int checks = 0;
  int passes = 0;
  logic [SW-1:0] cur_m;
  logic          ov_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // One cycle: compare at the falling edge, advance the model, then cross the rising edge.
  task automatic step();
    logic room_m, cap_m;
    logic [CH-1:0] rdy_m;
    word_t w;
    @(negedge clk);
    room_m = !ov_m || out_ready;
    rdy_m  = room_m ? (CH'(1) << cur_m) : '0;
    cap_m  = in_valid[cur_m] && room_m;
    check("in_ready", 32'(in_ready), 32'(rdy_m));
    check("out_valid", 32'(out_valid), 32'(ov_m));
    if (ov_m) begin
      if (exp_q.size() == 0) begin
        check("queue_nonempty", 32'(0), 32'(1));
      end else begin
        check("out_chan", 32'(out_chan), 32'(exp_q[0].chan));
        check("out_data", 32'(out_data), 32'(exp_q[0].data));
`ifdef SCAN_MUX_ONEHOT_EN
        check("onehot", 32'(out_chan_onehot), 32'(CH'(1) << exp_q[0].chan));
`endif
        if (out_ready) void'(exp_q.pop_front());
      end
    end else begin
`ifdef SCAN_MUX_ONEHOT_EN
      check("onehot_idle", 32'(out_chan_onehot), 32'(0));
`endif
    end
    if (cap_m) begin
      w.chan = cur_m;
      w.data = in_data[cur_m*W +: W];
      $display("capture chan=%0d data=%02h", w.chan, w.data);
      exp_q.push_back(w);
    end
    ov_m = cap_m ? 1'b1 : (room_m ? 1'b0 : ov_m);
    if (sel_load && sel < SW'(CH))               cur_m = sel;
    else if (mode && (cap_m || !in_valid[cur_m])) cur_m = (cur_m == SW'(CH-1)) ? '0 : cur_m + 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [SW-1:0] s);
    in_valid = '0; sel = s; sel_load = 1'b1;
    step();
    sel_load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_data = '0; in_valid = '0; mode = 1'b0;
    sel = '0; sel_load = 1'b0; out_ready = 1'b1;
    cur_m = '0; ov_m = 1'b0;
    in_valid = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'(0));
    check("rst_ready", 32'(in_ready), 32'(0));
    check("rst_data", 32'(out_data), 32'(0));
    check("rst_chan", 32'(out_chan), 32'(0));
    in_valid = '0;
    reset = 1'b0;

    // Manual select of channel 2
    load(3'd2);
    in_valid = 4'b0100; in_data = 32'h00A5_0000;
    step();
    in_valid = '0;
    step();

    // Scan skip 3 -> 0 -> 1 with wrap, capture from channel 1
    load(3'd3);
    mode = 1'b1; in_valid = 4'b0010; in_data = 32'h0000_3C00;
    repeat (3) step();
    in_valid = '0;
    step();

    // Backpressure for 5 cycles, then release
    mode = 1'b0;
    load(3'd0);
    in_valid = 4'b0001; in_data = 32'h0000_0011;
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_data = $urandom;
      step();
    end
    out_ready = 1'b1;
    step();
    in_valid = '0;
    step();

    // Full-rate scan over all channels
    mode = 1'b1;
    load(3'd0);
    in_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      in_data = $urandom;
      step();
    end

    // Capture from channel 1 with simultaneous sel_load to 3
    in_valid = '0;
    load(3'd1);
    in_valid = 4'b0010; in_data = 32'h0000_7700; sel = 3'd3; sel_load = 1'b1;
    step();
    sel_load = 1'b0; in_valid = 4'b1000; in_data = 32'h9900_0000;
    step();
    in_valid = '0;
    step();

    // Out-of-range select in both modes
    mode = 1'b0;
    load(3'd2);
    load(3'd5);
    in_valid = 4'b0100; in_data = 32'h0042_0000;
    step();
    mode = 1'b1; in_valid = '0;
    load(3'd5);
    load(3'd7);

    // Random mixed traffic
    for (int i = 0; i < 200; i++) begin
      in_data   = $urandom;
      in_valid  = CH'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      sel       = SW'($urandom);
      sel_load  = ($urandom_range(0, 7) == 0);
      step();
    end
    sel_load = 1'b0;

    // Asynchronous reset while a word is held under backpressure
    mode = 1'b0; in_valid = '0; out_ready = 1'b1;
    load(3'd1);
    in_valid = 4'b0010; in_data = 32'h0000_EE00;
    step();
    out_ready = 1'b0;
    step();
    reset = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'(0));
    check("arst_data", 32'(out_data), 32'(0));
    check("arst_chan", 32'(out_chan), 32'(0));
    check("arst_ready", 32'(in_ready), 32'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    cur_m = '0; ov_m = 1'b0;

    // First capture right after reset release
    out_ready = 1'b1; in_valid = 4'b0001; in_data = 32'h0000_005A;
    step();
    in_valid = '0;
    repeat (2) step();
    check("queue_drained", 32'(exp_q.size()), 32'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
